// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between the CPU
// memory stage (port 0) and a secondary master (port 1), with bounded lock.
module dmem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BURST_MAX     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     lock0,
  input  logic                     lock1,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDRESS_WIDTH-1:0] a0,
  input  logic [ADDRESS_WIDTH-1:0] a1,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  input  logic [2:0]               memctl0,
  input  logic [2:0]               memctl1,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic [DATA_WIDTH-1:0]    rdata0,
  output logic [DATA_WIDTH-1:0]    rdata1,
  output logic                     rvalid0,
  output logic                     rvalid1,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic                     mem_we,
  output logic [DATA_WIDTH-1:0]    mem_writedata,
  output logic [2:0]               mem_memcontrol,
  input  logic [DATA_WIDTH-1:0]    mem_readdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(BURST_MAX - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_last;
  logic                  w_last_nxt;
  logic [7:0]            r_beat_cnt;
  logic [7:0]            w_cnt_nxt;
  logic [7:0]            w_cnt_eff;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_keep;
  logic                  w_lock;
  logic                  w_other_req;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;
  logic                  r_rvalid0;
  logic                  r_rvalid1;

  // Grant: a live owner keeps the memory, otherwise round-robin on last.
  // Grants are held off while reset is asserted.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    w_keep = 1'b0;
    if (rst_n) begin
      if (r_state == OWN0 && req0) begin
        w_gnt0 = 1'b1;
        w_keep = 1'b1;
      end else if (r_state == OWN1 && req1) begin
        w_gnt1 = 1'b1;
        w_keep = 1'b1;
      end else if (req0 && req1) begin
        w_gnt0 = r_last;
        w_gnt1 = ~r_last;
      end else begin
        w_gnt0 = req0;
        w_gnt1 = req1;
      end
    end
  end

  // A beat that does not continue an existing ownership starts a fresh count.
  always_comb begin
    w_state_nxt = IDLE;
    w_cnt_nxt   = 8'd0;
    w_last_nxt  = r_last;
    w_lock      = w_gnt0 ? lock0 : lock1;
    w_other_req = w_gnt0 ? req1 : req0;
    w_cnt_eff   = w_keep ? r_beat_cnt : 8'd0;
    if (w_gnt0 || w_gnt1) begin
      w_last_nxt = w_gnt1;
      if (w_lock) begin
        if (w_cnt_eff == LP_CNT_LAST) begin
          if (!w_other_req) w_state_nxt = w_gnt0 ? OWN0 : OWN1;
        end else begin
          w_state_nxt = w_gnt0 ? OWN0 : OWN1;
          w_cnt_nxt   = w_cnt_eff + 8'd1;
        end
      end
    end
  end

  always_comb begin
    mem_a          = '0;
    mem_we         = 1'b0;
    mem_writedata  = '0;
    mem_memcontrol = 3'b010;
    if (w_gnt0) begin
      mem_a          = a0;
      mem_we         = we0;
      mem_writedata  = wdata0;
      mem_memcontrol = memctl0;
    end else if (w_gnt1) begin
      mem_a          = a1;
      mem_we         = we1;
      mem_writedata  = wdata1;
      mem_memcontrol = memctl1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_beat_cnt <= 8'd0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_beat_cnt <= w_cnt_nxt;
      r_rvalid0  <= w_gnt0 && !we0;
      r_rvalid1  <= w_gnt1 && !we1;
      if (w_gnt0 && !we0) r_rdata0 <= mem_readdata;
      if (w_gnt1 && !we1) r_rdata1 <= mem_readdata;
    end
  end

  assign gnt0    = w_gnt0;
  assign gnt1    = w_gnt1;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed vector bench for dmem_arbiter: one vector per clock, with a small
// word-addressed memory model behind the mem_* port.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, lock0, lock1, we0, we1;
  logic [31:0] a0, a1, wdata0, wdata1;
  logic [2:0]  memctl0, memctl1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_writedata;
  logic [2:0]  mem_memcontrol;
  logic [31:0] mem_readdata;

  logic [31:0] mem [0:1023];
  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .BURST_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .a0(a0), .a1(a1),
    .wdata0(wdata0), .wdata1(wdata1), .memctl0(memctl0), .memctl1(memctl1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .mem_a(mem_a), .mem_we(mem_we), .mem_writedata(mem_writedata),
    .mem_memcontrol(mem_memcontrol), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  assign mem_readdata = mem[mem_a[11:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[11:2]] <= mem_writedata;

  typedef struct {
    logic        rst_n, req0, req1, lock0, lock1, we0, we1;
    logic [31:0] a0, a1, wd0, wd1;
    logic        g0, g1, rv0, rv1;
    logic [31:0] rd0, rd1;
  } vec_t;

  localparam logic [31:0] A0 = 32'h0001_0000, AP0 = 32'h0001_0004, AP1 = 32'h0001_0008;
  localparam logic [31:0] A3 = 32'h0001_000C, A4 = 32'h0001_0010;
  localparam logic [31:0] CF = 32'hCAFE_F00D, DD = 32'hD00D_0004;
  localparam logic [31:0] D1 = 32'h1000_0001, D2 = 32'h1000_0002, D3 = 32'h1000_0003;

  vec_t vt [36];

  function automatic vec_t mk(input logic rs, r0, r1, l0, l1, w0, w1,
                              input logic [31:0] x0, x1, d0, d1,
                              input logic g0, g1, v0, v1,
                              input logic [31:0] e0, e1);
    vec_t v;
    v.rst_n = rs; v.req0 = r0; v.req1 = r1; v.lock0 = l0; v.lock1 = l1;
    v.we0 = w0; v.we1 = w1; v.a0 = x0; v.a1 = x1; v.wd0 = d0; v.wd1 = d1;
    v.g0 = g0; v.g1 = g1; v.rv0 = v0; v.rv1 = v1; v.rd0 = e0; v.rd1 = e1;
    return v;
  endfunction

  task automatic chk(input int idx, input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL v%0d %s got %h expected %h", idx, nm, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 | i;
    memctl0 = 3'b010;
    memctl1 = 3'b101;
    // reset, store/load round trip on port 0, idle hold, second reset
    vt[0]  = mk(0,1,0,0,0,0,0, A0,0,0,0,     0,0,0,0, 0,0);
    vt[1]  = mk(1,1,0,0,0,1,0, A0,0,CF,0,    1,0,0,0, 0,0);
    vt[2]  = mk(1,1,0,0,0,0,0, A0,0,0,0,     1,0,0,0, 0,0);
    vt[3]  = mk(1,0,0,0,0,0,0, 0,0,0,0,      0,0,1,0, CF,0);
    vt[4]  = mk(1,0,0,0,0,0,0, 0,0,0,0,      0,0,0,0, CF,0);
    vt[5]  = mk(0,0,0,0,0,0,0, 0,0,0,0,      0,0,0,0, 0,0);
    // tie alternation from reset
    vt[6]  = mk(1,1,1,0,0,0,0, AP0,AP1,0,0,  1,0,0,0, 0,0);
    vt[7]  = mk(1,1,1,0,0,0,0, AP0,AP1,0,0,  0,1,1,0, D1,0);
    vt[8]  = mk(1,1,1,0,0,0,0, AP0,AP1,0,0,  1,0,0,1, D1,D2);
    vt[9]  = mk(1,1,1,0,0,0,0, AP0,AP1,0,0,  0,1,1,0, D1,D2);
    vt[10] = mk(1,1,0,0,0,0,0, AP0,0,0,0,    1,0,0,1, D1,D2);
    // port 1 locked stores against a continuous port 0 load: forced yield
    vt[11] = mk(1,1,1,0,1,0,1, A3,A4,0,DD,   0,1,1,0, D1,D2);
    vt[12] = mk(1,1,1,0,1,0,1, A3,A4,0,DD,   0,1,0,0, D1,D2);
    vt[13] = mk(1,1,1,0,1,0,1, A3,A4,0,DD,   0,1,0,0, D1,D2);
    vt[14] = mk(1,1,1,0,1,0,1, A3,A4,0,DD,   0,1,0,0, D1,D2);
    vt[15] = mk(1,1,1,0,1,0,1, A3,A4,0,DD,   1,0,0,0, D1,D2);
    vt[16] = mk(1,1,1,0,1,0,1, A3,A4,0,DD,   0,1,1,0, D3,D2);
    vt[17] = mk(1,1,1,0,1,0,1, A3,A4,0,DD,   0,1,0,0, D3,D2);
    // ten locked loads with no contender
    vt[18] = mk(1,0,1,0,1,0,0, 0,A4,0,0,     0,1,0,0, D3,D2);
    for (int i = 19; i < 28; i++)
      vt[i] = mk(1,0,1,0,1,0,0, 0,A4,0,0,    0,1,0,1, D3,DD);
    // still owned after the count wraps: keeps grant although last favours port 0
    vt[28] = mk(1,1,1,0,1,0,0, AP0,A4,0,0,   0,1,0,1, D3,DD);
    // owner drops req in OWN1, then in OWN0
    vt[29] = mk(1,1,0,1,0,0,0, AP0,0,0,0,    1,0,0,1, D3,DD);
    vt[30] = mk(1,0,1,0,0,0,0, 0,AP1,0,0,    0,1,1,0, D1,DD);
    vt[31] = mk(1,0,0,0,0,0,0, 0,0,0,0,      0,0,0,1, D1,D2);
    // reset during a port 1 locked load burst
    vt[32] = mk(1,0,1,0,1,0,0, 0,AP1,0,0,    0,1,0,0, D1,D2);
    vt[33] = mk(0,0,1,0,1,0,0, 0,AP1,0,0,    0,0,0,0, 0,0);
    vt[34] = mk(1,1,1,0,0,0,0, AP0,AP1,0,0,  1,0,0,0, 0,0);
    vt[35] = mk(1,0,0,0,0,0,0, 0,0,0,0,      0,0,1,0, D1,0);

    rst_n = 1'b0;
    {req0, req1, lock0, lock1, we0, we1} = '0;
    a0 = '0; a1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 36; i++) begin
      logic [31:0] e_a, e_wd;
      logic [2:0]  e_ctl;
      logic        e_we;
      rst_n = vt[i].rst_n;
      req0 = vt[i].req0; req1 = vt[i].req1;
      lock0 = vt[i].lock0; lock1 = vt[i].lock1;
      we0 = vt[i].we0; we1 = vt[i].we1;
      a0 = vt[i].a0; a1 = vt[i].a1;
      wdata0 = vt[i].wd0; wdata1 = vt[i].wd1;
      e_a   = vt[i].g0 ? vt[i].a0  : vt[i].g1 ? vt[i].a1  : 32'h0;
      e_wd  = vt[i].g0 ? vt[i].wd0 : vt[i].g1 ? vt[i].wd1 : 32'h0;
      e_we  = vt[i].g0 ? vt[i].we0 : vt[i].g1 ? vt[i].we1 : 1'b0;
      e_ctl = vt[i].g1 ? 3'b101 : 3'b010;
      #1;
      chk(i, "gnt0", 32'(gnt0), 32'(vt[i].g0));
      chk(i, "gnt1", 32'(gnt1), 32'(vt[i].g1));
      chk(i, "mem_a", mem_a, e_a);
      chk(i, "mem_we", 32'(mem_we), 32'(e_we));
      chk(i, "mem_writedata", mem_writedata, e_wd);
      chk(i, "mem_memcontrol", 32'(mem_memcontrol), 32'(e_ctl));
      chk(i, "rvalid0", 32'(rvalid0), 32'(vt[i].rv0));
      chk(i, "rvalid1", 32'(rvalid1), 32'(vt[i].rv1));
      chk(i, "rdata0", rdata0, vt[i].rd0);
      chk(i, "rdata1", rdata1, vt[i].rd1);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-ported data memory. It shares the memory between the CPU memory stage (port 0) and a secondary master such as a DMA or debug loader (port 1). It uses round-robin arbitration with an optional bounded lock for back-to-back bursts. Read data is returned registered, with a one-cycle valid pulse per port.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, address width of both ports and the memory.
- DATA_WIDTH, 32, data width.
- BURST_MAX, 4, maximum consecutive locked beats before ownership must yield to a waiting requester; range 1–255.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req0, req1  in  1  request valid, per port.
- lock0, lock1  in  1  keep ownership after this beat.
- we0, we1  in  1  store when 1, load when 0.
- a0, a1  in  ADDRESS_WIDTH  byte address.
- wdata0, wdata1  in  DATA_WIDTH  store data.
- memctl0, memctl1  in  3  funct3 of the load/store, passed through unchanged.
- gnt0, gnt1  out  1  beat accepted this cycle (combinational).
- rdata0, rdata1  out  DATA_WIDTH  registered load result.
- rvalid0, rvalid1  out  1  one-cycle pulse, rdata valid.
- mem_a  out  ADDRESS_WIDTH  memory address.
- mem_we  out  1  memory write enable.
- mem_writedata  out  DATA_WIDTH  memory write data.
- mem_memcontrol  out  3  memory access type.
- mem_readdata  in  DATA_WIDTH  asynchronous read data from memory.

## Operation
- A beat is accepted on port i when reqi && gnti. At most one gnt is high per cycle.
- States:
  - IDLE: no owner.
  - OWN0: port 0 holds the lock.
  - OWN1: port 1 holds the lock.
- Registers:
  - state.
  - last (last granted port, 1 bit).
  - beat_cnt (8 bits).
  - rdata0/1 and rvalid0/1.
- Grant in IDLE:
  - Only one requester asserts req: that requester wins.
  - Both assert req: the port != last wins.
  - Neither asserts req: no grant.
- Grant in OWNi:
  - reqi=1: port i is granted and the other port is blocked.
  - reqi=0: ownership is released, and the cycle arbitrates exactly as in IDLE.
- Every accepted beat sets last to the granted port.
- State transitions on an accepted beat from port i:
  - lockI=0 → IDLE, beat_cnt=0.
  - lockI=1 and beat_cnt==BURST_MAX-1 and the other port's req=1 → IDLE, beat_cnt=0. This is a forced yield: the next cycle the other port wins via last.
  - lockI=1 and beat_cnt==BURST_MAX-1 and the other port's req=0 → OWNi, beat_cnt=0.
  - lockI=1 otherwise → OWNi, beat_cnt+1.
- The other port's req is sampled in the same cycle as the beat.
- Memory mux:
  - With a grant, the mem_* outputs carry the granted port's a/we/wdata/memctl.
  - With no grant: mem_we=0, mem_a=0, mem_writedata=0, mem_memcontrol=3'b010.
- Loads: on an accepted load from port i, mem_readdata is captured into rdatai at the posedge, and rvalidi=1 for the following cycle only.
- rdata holds its value until the next accepted load on that port.
- Stores never raise rvalid.
- No checking of memctl encoding; the memory defines the behaviour for illegal codes.

## Timing
- gnt, mem_a, mem_we, mem_writedata and mem_memcontrol are combinational from req, lock, state and last. Zero-cycle acceptance.
- Store latency: the write commits at the posedge ending the accept cycle.
- Load latency: 1 cycle. rvalid/rdata are visible in cycle N+1 for an accept in cycle N.
- Back-to-back loads produce back-to-back rvalid pulses.
- Throughput: one beat per cycle; no bubbles between ports on a switch.
- Reset values (asynchronous, on rst_n=0):
  - state=IDLE, last=1 (port 0 wins the first tie), beat_cnt=0.
  - rvalid0/1=0, rdata0/1=0.
- With all req low, the combinational outputs are the no-grant values.
- Reset asserted mid-burst drops ownership immediately and suppresses any pending rvalid. A write already presented with mem_we=1 may still commit if the posedge precedes the rst_n fall; the bench must not rely on either outcome.
- BURST_MAX=1: locked beats always yield to a waiting requester, which makes the arbitration plain round-robin.

## Test plan
- Reset then single requests:
  - rst_n low with req0=1 → gnt0=0, rvalid0=0.
  - After release, port 0 stores 32'hCAFEF00D (memctl 010) to 0x10000, then loads it.
  - Required: rdata0=32'hCAFEF00D with rvalid0 high exactly 1 cycle after the load accept.
- Tie alternation: both ports request continuous loads, lock=0.
  - Required: grants go 0,1,0,1… from reset.
  - Required: each rvalid pulse matches its own port's address data.
- Locked burst with forced yield, BURST_MAX=4: port 1 issues 6 locked stores while port 0 requests continuously.
  - Required: gnt1 for 4 cycles, then gnt0 for 1 cycle, then gnt1 resumes.
- Locked burst, no contender: port 1 issues 10 locked beats with req0=0.
  - Required: gnt1 every cycle, and beat_cnt wraps without IDLE.
- Owner drops req mid-lock: in OWN0, req0 falls while req1=1.
  - Required: gnt1 in that same cycle, and state leaves OWN0.
- Idle and reset mid-burst:
  - No requests → mem_we=0, mem_a=0, mem_memcontrol=010.
  - rst_n pulsed during a port-1 locked load burst → rvalid1 is 0 in the next cycle, and the next tie goes to port 0.
